// File: rtl/fsk_tx.sv
// fsk_tx: serial FSK transmitter. A 9-bit word is sent LSB first, one BIT_TICKS window per bit.
// Latency: the first window starts on the cycle after a load is accepted; a frame lasts 9*BIT_TICKS cycles, then done pulses for one cycle.
// Backpressure: ready is high only in IDLE; a load seen while busy is ignored and data_in is not sampled.
// Build option: define FSK_TX_PARITY_EN to replace bit 8 of the latched word with even parity of data_in[7:0].
module fsk_tx #(
  parameter int BIT_TICKS = 64,
  parameter int F1_HALF   = 2,
  parameter int F0_HALF   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] data_in,
  input  logic       load,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       bit_clk,
  output logic       fsk_out
);

  // Counter sizing: tick spans one bit window, tone spans the longer half-period.
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int TICK_W     = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
  localparam int HMAX       = (F1_HALF > F0_HALF) ? F1_HALF : F0_HALF;
  localparam int TONE_W     = (HMAX > 2) ? $clog2(HMAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(HALF_TICKS);
  localparam logic [TONE_W-1:0] F1_LAST   = TONE_W'(F1_HALF - 1);
  localparam logic [TONE_W-1:0] F0_LAST   = TONE_W'(F0_HALF - 1);
  localparam logic [3:0]        LAST_BIT  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [8:0]          shreg_q, shreg_d;
  logic [3:0]          bit_idx_q, bit_idx_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [TONE_W-1:0]   tone_q, tone_d;
  logic                fsk_q, fsk_d;
  logic                done_q, done_d;

  logic [8:0]          load_word;
  logic                cur_bit;
  logic [TONE_W-1:0]   tone_last;

`ifdef FSK_TX_PARITY_EN
  // Word as latched at load: bit 8 carries even parity of the low byte.
  always_comb begin
    load_word = {^data_in[7:0], data_in[7:0]};
  end
`else
  // Word as latched at load: all nine bits taken as given.
  always_comb begin
    load_word = data_in;
  end
`endif

  // Tone selection for the bit currently on the line.
  always_comb begin
    cur_bit   = shreg_q[bit_idx_q];
    tone_last = cur_bit ? F1_LAST : F0_LAST;
  end

  // State register and datapath registers; reset returns every output to idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tick_q    <= '0;
      tone_q    <= '0;
      fsk_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tick_q    <= tick_d;
      tone_q    <= tone_d;
      fsk_q     <= fsk_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: load acceptance, window sequencing and tone generation.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    tick_d    = tick_q;
    tone_d    = tone_q;
    fsk_d     = fsk_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Line stays quiet and counters parked at zero so every frame starts in phase.
        tick_d    = '0;
        tone_d    = '0;
        fsk_d     = 1'b0;
        bit_idx_d = '0;
        if (load) begin
          shreg_d = load_word;
          state_d = SEND;
        end
      end

      SEND: begin
        if (tick_q == TICK_LAST) begin
          // Window boundary: restart tone phase so the next window begins low.
          tick_d = '0;
          tone_d = '0;
          fsk_d  = 1'b0;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = IDLE;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
          if (tone_q == tone_last) begin
            tone_d = '0;
            fsk_d  = ~fsk_q;
          end else begin
            tone_d = tone_q + TONE_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state, so reset clears them without a clock.
  always_comb begin
    ready   = (state_q == IDLE);
    busy    = (state_q == SEND);
    done    = done_q;
    bit_clk = (state_q == SEND) && (tick_q < TICK_HALF);
    fsk_out = fsk_q;
  end

endmodule
